// File: rtl/hazard_sequencer_pkg.sv
// Shared hazard codes, FSM state encoding and register constants for hazard_sequencer.
// Optional statistics counters are enabled in the top by defining HAZ_SEQ_STATS_EN.
package hazard_sequencer_pkg;

  localparam logic [1:0] HAZ_NONE   = 2'b00;
  localparam logic [1:0] HAZ_BUBBLE = 2'b01;
  localparam logic [1:0] HAZ_FLUSH  = 2'b10;
  localparam logic [1:0] HAZ_STALL  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Hazard code for the no-memory-stall case; loadUse outranks ctrl.
  function automatic logic [1:0] idle_haz(input logic load_use, input logic ctrl);
    if (load_use)  return HAZ_BUBBLE;
    else if (ctrl) return HAZ_FLUSH;
    else           return HAZ_NONE;
  endfunction

endpackage

// File: rtl/hazard_detect_comb.sv
// Purely combinational hazard term generator: memory stall, load-use and control transfer.
module hazard_detect_comb
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  BranchTaken,
  input  logic                  Jump,
  input  logic                  MemReq,
  input  logic                  MemReady,
  output logic                  memStall,
  output logic                  loadUse,
  output logic                  ctrl
);

  logic rt_nonzero;
  logic rt_match;

  // A load into r0 never creates a dependency since r0 is hardwired.
  assign rt_nonzero = (IDEX_Rt != REG_ADDR_W'(REG_ZERO));
  assign rt_match   = (IDEX_Rt == IFID_Rs) | (IDEX_Rt == IFID_Rt);

  assign memStall = MemReq & ~MemReady;
  assign loadUse  = IDEX_MemRead & rt_nonzero & rt_match;
  assign ctrl     = BranchTaken | Jump;

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: arbitrates memory stalls, load-use bubbles and branch flushes into hazType.
// Define HAZ_SEQ_STATS_EN to add saturating stall/bubble/flush cycle counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  BranchTaken,
  input  logic                  Jump,
  input  logic                  MemReq,
  input  logic                  MemReady,
  output logic [1:0]            hazType,
  output logic                  busy,
  output logic                  memTimeout
`ifdef HAZ_SEQ_STATS_EN
  ,
  output logic [15:0]           stallCount,
  output logic [15:0]           bubbleCount,
  output logic [15:0]           flushCount
`endif
);

  localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX    = 8'(MEM_TIMEOUT);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  logic       memStall;
  logic       loadUse;
  logic       ctrl;
  state_e     state;
  logic [2:0] flushCnt;
  logic [7:0] waitCnt;
  logic       flushPend;
  logic [1:0] haz_c;
  logic       start_flush;

  hazard_detect_comb #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .MemReq       (MemReq),
    .MemReady     (MemReady),
    .memStall     (memStall),
    .loadUse      (loadUse),
    .ctrl         (ctrl)
  );

  // A control transfer only needs the FLUSH state when more than one flush cycle is required.
  assign start_flush = ~loadUse & ctrl & MULTI_FLUSH;

  // Mealy output: stall is asserted in the very cycle the hazard is detected.
  always_comb begin
    haz_c = HAZ_NONE;
    case (state)
      IDLE:     haz_c = memStall ? HAZ_STALL : idle_haz(loadUse, ctrl);
      MEM_WAIT: begin
        if (MemReady)               haz_c = idle_haz(loadUse, ctrl);
        else if (waitCnt == WAIT_MAX) haz_c = HAZ_NONE;
        else                        haz_c = HAZ_STALL;
      end
      FLUSH:    haz_c = memStall ? HAZ_STALL : HAZ_FLUSH;
      default:  haz_c = HAZ_NONE;
    endcase
    if (Reset) haz_c = HAZ_NONE;
  end

  assign hazType = haz_c;
  assign busy    = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      flushCnt   <= 3'd0;
      waitCnt    <= 8'd0;
      flushPend  <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memStall) begin
            state   <= MEM_WAIT;
            waitCnt <= 8'd1;
          end else if (start_flush) begin
            state    <= FLUSH;
            flushCnt <= 3'd1;
          end
        end
        MEM_WAIT: begin
          if (MemReady) begin
            waitCnt <= 8'd0;
            if (flushPend) begin
              // Resume the interrupted flush where it left off.
              state     <= FLUSH;
              flushPend <= 1'b0;
            end else if (start_flush) begin
              state    <= FLUSH;
              flushCnt <= 3'd1;
            end else begin
              state <= IDLE;
            end
          end else if (waitCnt == WAIT_MAX) begin
            memTimeout <= 1'b1;
            waitCnt    <= 8'd0;
            flushPend  <= 1'b0;
            flushCnt   <= 3'd0;
            state      <= IDLE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        FLUSH: begin
          if (memStall) begin
            flushPend <= 1'b1;
            waitCnt   <= 8'd1;
            state     <= MEM_WAIT;
          end else if (flushCnt == FLUSH_LAST) begin
            flushCnt <= 3'd0;
            state    <= IDLE;
          end else begin
            flushCnt <= flushCnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZ_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCount  <= 16'd0;
      bubbleCount <= 16'd0;
      flushCount  <= 16'd0;
    end else begin
      if (haz_c == HAZ_STALL)  stallCount  <= sat_inc(stallCount);
      if (haz_c == HAZ_BUBBLE) bubbleCount <= sat_inc(bubbleCount);
      if (haz_c == HAZ_FLUSH)  flushCount  <= sat_inc(flushCount);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed bench for hazard_sequencer against a sequence-level reference model.
// Also covers the HAZ_SEQ_STATS_EN counters when that macro is defined.
module tb_hazard_sequencer;

  localparam int FC = 3;
  localparam int MT = 16;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          IDEX_MemRead;
  logic [AW-1:0] IDEX_Rt;
  logic [AW-1:0] IFID_Rs;
  logic [AW-1:0] IFID_Rt;
  logic          BranchTaken;
  logic          Jump;
  logic          MemReq;
  logic          MemReady;
  logic [1:0]    hazType;
  logic          busy;
  logic          memTimeout;
`ifdef HAZ_SEQ_STATS_EN
  logic [15:0]   stallCount;
  logic [15:0]   bubbleCount;
  logic [15:0]   flushCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining flush cycles, wait length, and a pending-resume flag.
  bit in_wait;
  int flush_left;
  int waited;
  bit resume;
  bit tmo;
  int cnt_stall, cnt_bubble, cnt_flush;
  int exp_haz;

  hazard_sequencer #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (MT),
    .REG_ADDR_W   (AW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .MemReq       (MemReq),
    .MemReady     (MemReady),
    .hazType      (hazType),
    .busy         (busy),
    .memTimeout   (memTimeout)
`ifdef HAZ_SEQ_STATS_EN
    ,
    .stallCount   (stallCount),
    .bubbleCount  (bubbleCount),
    .flushCount   (flushCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_lu();
    return IDEX_MemRead && (IDEX_Rt != 0) && ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  endfunction

  function automatic bit m_ct();
    return BranchTaken || Jump;
  endfunction

  function automatic int m_no_mem_code();
    if (m_lu())      return 1;
    else if (m_ct()) return 2;
    else             return 0;
  endfunction

  function automatic int m_code();
    bit ms;
    ms = MemReq && !MemReady;
    if (in_wait) begin
      if (MemReady)          return m_no_mem_code();
      else if (waited == MT) return 0;
      else                   return 3;
    end else if (flush_left > 0) begin
      return ms ? 3 : 2;
    end else begin
      return ms ? 3 : m_no_mem_code();
    end
  endfunction

  task automatic model_reset();
    in_wait = 0; flush_left = 0; waited = 0; resume = 0; tmo = 0;
    cnt_stall = 0; cnt_bubble = 0; cnt_flush = 0;
  endtask

  task automatic model_commit();
    bit ms;
    bit new_flush;
    ms = MemReq && !MemReady;
    new_flush = !m_lu() && m_ct() && (FC > 1);
    if (exp_haz == 3) cnt_stall++;
    if (exp_haz == 1) cnt_bubble++;
    if (exp_haz == 2) cnt_flush++;
    if (in_wait) begin
      if (MemReady) begin
        in_wait = 0; waited = 0;
        if (resume) resume = 0;
        else if (new_flush) flush_left = FC - 1;
      end else if (waited == MT) begin
        in_wait = 0; waited = 0; resume = 0; flush_left = 0; tmo = 1;
      end else begin
        waited++;
      end
    end else if (flush_left > 0) begin
      if (ms) begin
        in_wait = 1; waited = 1; resume = 1;
      end else begin
        flush_left--;
      end
    end else if (ms) begin
      in_wait = 1; waited = 1;
    end else if (new_flush) begin
      flush_left = FC - 1;
    end
  endtask

  task automatic set_in(input bit mr, input int rt, input int rs, input int rt2,
                        input bit br, input bit j, input bit mq, input bit rdy);
    IDEX_MemRead = mr;
    IDEX_Rt      = AW'(rt);
    IFID_Rs      = AW'(rs);
    IFID_Rt      = AW'(rt2);
    BranchTaken  = br;
    Jump         = j;
    MemReq       = mq;
    MemReady     = rdy;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: sample mid-cycle against the model, then advance both across the edge.
  task automatic step(input string tag);
    #3;
    exp_haz = m_code();
    check_val({tag, ".haz"}, 32'(hazType), 32'(exp_haz));
    check_val({tag, ".busy"}, 32'(busy), 32'(in_wait || flush_left > 0));
    check_val({tag, ".tmo"}, 32'(memTimeout), 32'(tmo));
    @(posedge Clk);
    model_commit();
    #1;
  endtask

`ifdef HAZ_SEQ_STATS_EN
  task automatic check_stats(input string tag);
    check_val({tag, ".stall"}, 32'(stallCount), 32'(cnt_stall > 65535 ? 65535 : cnt_stall));
    check_val({tag, ".bubble"}, 32'(bubbleCount), 32'(cnt_bubble > 65535 ? 65535 : cnt_bubble));
    check_val({tag, ".flush"}, 32'(flushCount), 32'(cnt_flush > 65535 ? 65535 : cnt_flush));
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_hold;
    Reset = 1'b1;
    idle_in();
    model_reset();
    repeat (2) @(posedge Clk);
    #3;
    check_val("rst.haz", 32'(hazType), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.tmo", 32'(memTimeout), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Load-use bubble, then the r0 exception
    set_in(1, 5, 5, 0, 0, 0, 0, 0); step("lu");
    idle_in();                      step("lu_after");
    set_in(1, 0, 0, 0, 0, 0, 0, 0); step("lu_r0");
    idle_in();                      step("lu_r0_after");

    // Taken branch: three flush cycles
    set_in(0, 0, 0, 0, 1, 0, 0, 0); step("br");
    idle_in();
    repeat (4) step("br_tail");

    // Four-cycle memory wait
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step("mw");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); step("mw_rdy");
    idle_in();                      step("mw_after");

    // Memory timeout and sticky flag
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (18) step("to");
    idle_in();
    repeat (3) step("to_after");

    // Memory stall preempting a flush
    set_in(0, 0, 0, 0, 1, 0, 0, 0); step("pre_br");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step("pre_ms");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); step("pre_rdy");
    idle_in();
    repeat (4) step("pre_tail");

    // All three hazards at once
    set_in(1, 5, 5, 0, 1, 1, 1, 0); step("sim");
    set_in(1, 5, 5, 0, 1, 1, 1, 1); step("sim_rdy");
    idle_in();
    repeat (3) step("sim_tail");

    // Asynchronous reset in the middle of a memory wait
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step("rw");
    #2;
    Reset = 1'b1;
    #1;
    check_val("rw_rst.haz", 32'(hazType), 32'd0);
    check_val("rw_rst.busy", 32'(busy), 32'd0);
    check_val("rw_rst.tmo", 32'(memTimeout), 32'd0);
    model_reset();
`ifdef HAZ_SEQ_STATS_EN
    check_stats("rw_rst");
`endif
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle_in();
    step("rw_after");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step("rw_again");
    idle_in();

    // Randomized traffic with occasional long memory waits
    low_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if (low_hold == 0 && $urandom_range(0, 299) == 0) low_hold = $urandom_range(14, 24);
      if (low_hold > 0) begin
        rdy = 1'b0;
        low_hold--;
      end else begin
        rdy = $urandom_range(0, 1);
      end
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             (low_hold > 0) || ($urandom_range(0, 2) == 0), rdy);
      step("rnd");
    end
    idle_in();
    step("final");
`ifdef HAZ_SEQ_STATS_EN
    check_stats("final");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
